// File: rtl/target_lut_pkg.sv
// Shared constants for the PC-target lookup table and its reverse encoder.
package target_lut_pkg;

  localparam int PC_WIDTH_DEFAULT = 12;
  localparam int ENTRIES          = 16;
  localparam int IDX_W            = 4;

  // Standard target constants, also loaded by the forward LUT at reset
  localparam logic [PC_WIDTH_DEFAULT-1:0] RESET_TARGETS [ENTRIES] = '{
    12'h0FC, 12'h019, 12'h03B, 12'h03D, 12'h011, 12'h015, 12'h01B, 12'h03A,
    12'h03F, 12'h047, 12'h05C, 12'h05D, 12'h07F, 12'h09B, 12'h0A4, 12'h001
  };

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } state_t;

endpackage

// File: rtl/target_table.sv
// 16-entry PC target register file: synchronous write, combinational read,
// synchronous reset back to the standard target constants.
module target_table
  import target_lut_pkg::*;
#(
  parameter int PC_width = PC_WIDTH_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [PC_width-1:0] wr_data,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [PC_width-1:0] rd_data
);

  logic [PC_width-1:0] mem [ENTRIES];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= PC_width'(RESET_TARGETS[i]);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-edge value, so a same-cycle write never affects a compare
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/target_lut_encoder.sv
// Reverse lookup: sequentially searches the target table for a PC and returns
// the lowest matching index, or a miss after entry 15.
//   state  | meaning
//   IDLE   | ready for a request
//   SEARCH | comparing entry[cnt] with the latched target, one per cycle
//   RESP   | result held until the consumer takes it
module target_lut_encoder
  import target_lut_pkg::*;
#(
  parameter int PC_width = PC_WIDTH_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [PC_width-1:0] wr_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [PC_width-1:0] req_target,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDX_W-1:0]    rsp_index,
  output logic                rsp_hit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [PC_width-1:0] target_q, target_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [PC_width-1:0] entry;
  logic                match;

  target_table #(
    .PC_width (PC_width)
  ) u_table (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (cnt_q),
    .rd_data (entry)
  );

  assign match = (entry == target_q);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          cnt_d    = '0;
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        if (match) begin
          idx_d   = cnt_q;
          hit_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q == LAST_IDX) begin
          idx_d   = '0;
          hit_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_index = idx_q;
  assign rsp_hit   = hit_q;

endmodule

// File: tb/tb_target_lut_encoder.sv
// Directed bench for target_lut_encoder with a cycle-stamped reference model.
module tb_target_lut_encoder;

  logic        Clk;
  logic        Reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_target;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_index;
  logic        rsp_hit;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  target_lut_encoder dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_index  (rsp_index),
    .rsp_hit    (rsp_hit)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  localparam logic [11:0] RST_TBL [16] = '{
    12'h0FC, 12'h019, 12'h03B, 12'h03D, 12'h011, 12'h015, 12'h01B, 12'h03A,
    12'h03F, 12'h047, 12'h05C, 12'h05D, 12'h07F, 12'h09B, 12'h0A4, 12'h001
  };

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: a request accepted at the edge ending cycle t0 compares entry k
  // against the table as it stands during cycle t0+1+k (writes land after).
  logic [11:0] m_tbl [16];
  logic [11:0] m_tgt;
  bit          m_busy, m_done, m_hit;
  int          m_idx, m_t0, k;
  int          cyc = 0;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) m_tbl[i] = RST_TBL[i];
      m_busy = 0;
      m_done = 0;
    end else begin
      if (m_busy && !m_done) begin
        k = cyc - m_t0 - 1;
        if (m_tbl[k] == m_tgt) begin
          m_done = 1; m_hit = 1; m_idx = k;
        end else if (k == 15) begin
          m_done = 1; m_hit = 0; m_idx = 0;
        end
      end else if (m_busy && m_done) begin
        if (rsp_ready) m_busy = 0;
      end else if (req_valid) begin
        m_busy = 1; m_done = 0; m_t0 = cyc; m_tgt = req_target;
      end
      if (wr_en) m_tbl[wr_addr] = wr_data;
    end
    cyc++;
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model req_ready", req_ready, !m_busy);
      chk("model rsp_valid", rsp_valid, m_busy && m_done);
      if (m_busy && m_done) begin
        chk("model rsp_index", rsp_index, m_idx[3:0]);
        chk("model rsp_hit", rsp_hit, m_hit);
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    @(posedge Clk); #1;
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge Clk); #1;
    wr_en = 0;
  endtask

  // wc: cycle offset after accept at which to pulse a write (-1 = none)
  task automatic do_req(input string nm, input logic [11:0] tgt, input logic e_hit,
                        input int e_idx, input int e_lat, input int hold,
                        input int wc, input logic [3:0] wa, input logic [11:0] wd);
    int lat;
    @(posedge Clk); #1;
    req_valid = 1; req_target = tgt;
    @(posedge Clk); #1;
    req_valid = 0; req_target = '0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      wr_en = (n == wc); wr_addr = wa; wr_data = wd;
      @(negedge Clk);
      if (rsp_valid && lat < 0) lat = n;
      if (lat >= 0 && n > wc) break;
      @(posedge Clk); #1;
    end
    wr_en = 0;
    chk({nm, " latency"}, lat, e_lat);
    repeat (hold) @(posedge Clk);
    @(negedge Clk);
    chk({nm, " rsp_valid"}, rsp_valid, 1);
    chk({nm, " req_ready"}, req_ready, 0);
    chk({nm, " rsp_hit"}, rsp_hit, e_hit);
    chk({nm, " rsp_index"}, rsp_index, e_idx);
    rsp_ready = 1;
    @(posedge Clk); #1;
    rsp_ready = 0;
    @(negedge Clk);
    chk({nm, " ready after take"}, req_ready, 1);
    chk({nm, " valid after take"}, rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    req_valid = 0; req_target = '0; rsp_ready = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1;
    chk_en = 1;
    @(negedge Clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_index", rsp_index, 0);
    chk("reset rsp_hit", rsp_hit, 0);

    do_req("hit 03B", 12'h03B, 1, 2, 4, 0, -1, 4'd0, 12'h000);
    do_req("miss 123", 12'h123, 0, 0, 17, 0, -1, 4'd0, 12'h000);
    wr(4'd5, 12'h03B);
    do_req("lowest wins", 12'h03B, 1, 2, 4, 0, -1, 4'd0, 12'h000);
    wr(4'd2, 12'h000);
    do_req("after clear e2", 12'h03B, 1, 5, 7, 0, -1, 4'd0, 12'h000);
    do_req("write ahead", 12'h0A4, 0, 0, 17, 0, 3, 4'd14, 12'h000);
    do_req("write behind", 12'h0FC, 1, 0, 2, 0, 4, 4'd0, 12'h123);
    do_req("new e0", 12'h123, 1, 0, 2, 0, -1, 4'd0, 12'h000);
    do_req("hold resp", 12'h047, 1, 9, 11, 10, -1, 4'd0, 12'h000);
    do_req("last entry", 12'h001, 1, 15, 17, 0, -1, 4'd0, 12'h000);
    do_req("same-edge write", 12'h03D, 1, 3, 5, 0, 4, 4'd3, 12'h777);

    // reset aborts a search and restores the table
    wr(4'd3, 12'h555);
    @(posedge Clk); #1;
    req_valid = 1; req_target = 12'h001;
    @(posedge Clk); #1;
    req_valid = 0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 0;
    @(posedge Clk); #1;
    Reset_n = 1;
    @(negedge Clk);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort req_ready", req_ready, 1);
    do_req("restored e3", 12'h03D, 1, 3, 5, 0, -1, 4'd0, 12'h000);
    do_req("restored e2", 12'h03B, 1, 2, 4, 0, -1, 4'd0, 12'h000);
    do_req("restored e14", 12'h0A4, 1, 14, 16, 0, -1, 4'd0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
